// File: rtl/midi_pkg.sv
// midi_pkg: shared constants and types for the MIDI-to-floppy voice controller.
// Holds status nibbles, controller numbers, setpoint width, parser state and
// the internal action code passed from the parser stage to the voice stage.
package midi_pkg;

  localparam int SP_W = 22;

  localparam logic [3:0] NOTE_OFF = 4'h8;
  localparam logic [3:0] NOTE_ON  = 4'h9;
  localparam logic [3:0] CC       = 4'hB;
  localparam logic [3:0] PROG     = 4'hC;
  localparam logic [3:0] CHPRESS  = 4'hD;

  localparam logic [6:0] CC_ALL_SOUND_OFF = 7'd120;
  localparam logic [6:0] CC_ALL_NOTES_OFF = 7'd123;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA1 = 2'd1,
    DATA2 = 2'd2
  } par_state_e;

  // What a completed message asks the voice stage to do.
  typedef enum logic [1:0] {
    ACT_NONE    = 2'd0,
    ACT_ON      = 2'd1,
    ACT_OFF     = 2'd2,
    ACT_SILENCE = 2'd3
  } act_e;

endpackage

// File: rtl/note_period_rom.sv
// note_period_rom: 128 x SP_W table of step periods in clock cycles per MIDI note.
// Ports: clk_i clock; addr_i note number; data_o registered period (1-cycle read).
// Entries are constants evaluated at elaboration from CLK_RATE (A4 = 440 Hz).
module note_period_rom
  import midi_pkg::*;
#(
  parameter int CLK_RATE = 50000000
) (
  input  logic            clk_i,
  input  logic [6:0]      addr_i,
  output logic [SP_W-1:0] data_o
);

  logic [SP_W-1:0] tbl [128];
  logic [SP_W-1:0] data_q;

  // Real-to-integer cast rounds to nearest; low notes that overflow SP_W are
  // outside the playable range and are simply truncated.
  for (genvar k = 0; k < 128; k++) begin : g_rom
    localparam real    PERIOD = real'(CLK_RATE) /
                                (440.0 * (2.0 ** ((real'(k) - 69.0) / 12.0)));
    localparam longint CYC    = longint'(PERIOD);
    assign tbl[k] = CYC[SP_W-1:0];
  end

  always_ff @(posedge clk_i) begin
    data_q <= tbl[addr_i];
  end

  assign data_o = data_q;

endmodule

// File: rtl/midi_floppy_ctrl.sv
// midi_floppy_ctrl: parses MIDI channel voice bytes and drives 8 floppy voices.
// Ports: clk/rst; rx_data + new_rx_data byte strobe in; f_sp/f_en/note_active
// per-drive outputs (update 2 cycles after final byte); err_pulse on orphan data.
module midi_floppy_ctrl
  import midi_pkg::*;
#(
  parameter int CLK_RATE   = 50000000,
  parameter int NOTE_MIN   = 24,
  parameter int NOTE_MAX   = 83,
  parameter int NUM_DRIVES = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [7:0]                 rx_data,
  input  logic                       new_rx_data,
  output logic [SP_W*NUM_DRIVES-1:0] f_sp,
  output logic [NUM_DRIVES-1:0]      f_en,
  output logic [NUM_DRIVES-1:0]      note_active,
  output logic                       err_pulse
);

  localparam logic [6:0] NOTE_LO = 7'(NOTE_MIN);
  localparam logic [6:0] NOTE_HI = 7'(NOTE_MAX);

  // Parser state
  par_state_e state_q, state_d;
  logic [3:0] rs_q, rs_d;          // running status nibble
  logic [3:0] chan_q, chan_d;
  logic       rs_vld_q, rs_vld_d;
  logic       sysex_q, sysex_d;    // dropping data after a system common byte
  logic [6:0] d1_q, d1_d;
  logic       err_q, err_d;

  // Stage 1: decoded action, aligned with the ROM read
  act_e       act_q, act_d;
  logic [2:0] act_ch_q, act_ch_d;
  logic [6:0] act_note_q, act_note_d;

  // Stage 2: voice state
  logic [NUM_DRIVES-1:0] en_q, en_d;
  logic [SP_W-1:0]       sp_q   [NUM_DRIVES];
  logic [SP_W-1:0]       sp_d   [NUM_DRIVES];
  logic [6:0]            note_q [NUM_DRIVES];
  logic [6:0]            note_d [NUM_DRIVES];

  logic            done;
  logic            one_byte;
  logic [6:0]      d2;
  logic [SP_W-1:0] rom_dat;

  assign one_byte = (rs_q == PROG) || (rs_q == CHPRESS);
  assign d2       = rx_data[6:0];

  note_period_rom #(.CLK_RATE(CLK_RATE)) u_rom (
    .clk_i  (clk),
    .addr_i (d1_q),
    .data_o (rom_dat)
  );

  // Byte classification and message assembly
  always_comb begin
    state_d  = state_q;
    rs_d     = rs_q;
    chan_d   = chan_q;
    rs_vld_d = rs_vld_q;
    sysex_d  = sysex_q;
    d1_d     = d1_q;
    err_d    = 1'b0;
    done     = 1'b0;
    if (new_rx_data) begin
      if (rx_data >= 8'hF8) begin
        // realtime: transparent to the parser
      end else if (rx_data >= 8'hF0) begin
        rs_vld_d = 1'b0;
        sysex_d  = 1'b1;
        state_d  = IDLE;
      end else if (rx_data[7]) begin
        rs_d     = rx_data[7:4];
        chan_d   = rx_data[3:0];
        rs_vld_d = 1'b1;
        sysex_d  = 1'b0;
        state_d  = DATA1;
      end else if (state_q == DATA2) begin
        done    = 1'b1;
        state_d = DATA1;
      end else if (state_q == DATA1 || rs_vld_q) begin
        d1_d    = rx_data[6:0];
        done    = one_byte;
        state_d = one_byte ? DATA1 : DATA2;
      end else if (!sysex_q) begin
        err_d = 1'b1;
      end
    end
  end

  // Message decode; d1 of a completing two-byte message is already in d1_q
  always_comb begin
    act_d      = ACT_NONE;
    act_ch_d   = chan_q[2:0];
    act_note_d = d1_q;
    if (done && !chan_q[3]) begin
      case (rs_q)
        NOTE_ON: begin
          if (d2 == 7'd0)                              act_d = ACT_OFF;
          else if (d1_q >= NOTE_LO && d1_q <= NOTE_HI) act_d = ACT_ON;
        end
        NOTE_OFF: act_d = ACT_OFF;
        CC: begin
          if (d1_q == CC_ALL_SOUND_OFF || d1_q == CC_ALL_NOTES_OFF)
            act_d = ACT_SILENCE;
        end
        default: act_d = ACT_NONE;
      endcase
    end
  end

  // Voice update; note-off match is checked against live state so that
  // messages completing two cycles apart see each other's effect.
  always_comb begin
    en_d   = en_q;
    sp_d   = sp_q;
    note_d = note_q;
    case (act_q)
      ACT_ON: begin
        note_d[act_ch_q] = act_note_q;
        sp_d[act_ch_q]   = rom_dat;
        en_d[act_ch_q]   = 1'b1;
      end
      ACT_OFF: begin
        if (en_q[act_ch_q] && note_q[act_ch_q] == act_note_q)
          en_d[act_ch_q] = 1'b0;
      end
      ACT_SILENCE: en_d[act_ch_q] = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rs_q       <= 4'd0;
      chan_q     <= 4'd0;
      rs_vld_q   <= 1'b0;
      sysex_q    <= 1'b0;
      d1_q       <= 7'd0;
      err_q      <= 1'b0;
      act_q      <= ACT_NONE;
      act_ch_q   <= 3'd0;
      act_note_q <= 7'd0;
      en_q       <= '0;
      for (int i = 0; i < NUM_DRIVES; i++) begin
        sp_q[i]   <= '0;
        note_q[i] <= 7'd0;
      end
    end else begin
      state_q    <= state_d;
      rs_q       <= rs_d;
      chan_q     <= chan_d;
      rs_vld_q   <= rs_vld_d;
      sysex_q    <= sysex_d;
      d1_q       <= d1_d;
      err_q      <= err_d;
      act_q      <= act_d;
      act_ch_q   <= act_ch_d;
      act_note_q <= act_note_d;
      en_q       <= en_d;
      sp_q       <= sp_d;
      note_q     <= note_d;
    end
  end

  for (genvar g = 0; g < NUM_DRIVES; g++) begin : g_pack
    assign f_sp[g*SP_W +: SP_W] = sp_q[g];
  end

  assign f_en        = en_q;
  assign note_active = en_q;
  assign err_pulse   = err_q;

endmodule

// File: tb/tb_midi_floppy_ctrl.sv
// tb_midi_floppy_ctrl: directed tests for the MIDI floppy controller.
// Bytes are driven on falling edges; outputs are sampled on falling edges.
// Expected setpoints are hand-computed note periods at 50 MHz.
module tb_midi_floppy_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   rx_data;
  logic         new_rx_data;
  logic [175:0] f_sp;
  logic [7:0]   f_en;
  logic [7:0]   note_active;
  logic         err_pulse;

  int n_cmp  = 0;
  int n_fail = 0;
  int err_cnt = 0;

  localparam logic [21:0] R24 = 22'd1528903;
  localparam logic [21:0] R60 = 22'd191113;
  localparam logic [21:0] R62 = 22'd170262;
  localparam logic [21:0] R64 = 22'd151686;
  localparam logic [21:0] R65 = 22'd143173;
  localparam logic [21:0] R69 = 22'd113636;
  localparam logic [21:0] R83 = 22'd50619;

  midi_floppy_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (rx_data),
    .new_rx_data (new_rx_data),
    .f_sp        (f_sp),
    .f_en        (f_en),
    .note_active (note_active),
    .err_pulse   (err_pulse)
  );

  always #5 clk = ~clk;

  function automatic logic [21:0] lane(input int ch);
    return f_sp[ch*22 +: 22];
  endfunction

  // Called on a falling edge; returns on the next falling edge with the strobe
  // dropped, at which point err_pulse belongs to this byte.
  task automatic send(input logic [7:0] b);
    rx_data     = b;
    new_rx_data = 1'b1;
    @(negedge clk);
    new_rx_data = 1'b0;
    if (err_pulse === 1'b1) err_cnt++;
  endtask

  task automatic idle(input int n);
    new_rx_data = 1'b0;
    repeat (n) begin
      @(negedge clk);
      if (err_pulse === 1'b1) err_cnt++;
    end
  endtask

  task automatic do_reset;
    new_rx_data = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    err_cnt = 0;
  endtask

  task automatic test_reset;
    do_reset();
    n_cmp++; if (f_sp !== 176'd0) begin n_fail++; $display("FAIL reset_f_sp: got %h want 0", f_sp); end
    n_cmp++; if (f_en !== 8'h00) begin n_fail++; $display("FAIL reset_f_en: got %h want 00", f_en); end
    n_cmp++; if (note_active !== 8'h00) begin n_fail++; $display("FAIL reset_note_active: got %h want 00", note_active); end
    n_cmp++; if (err_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err_pulse); end
  endtask

  task automatic test_note_on;
    send(8'h90); send(8'h45); send(8'h64);
    // one cycle after the final strobe nothing is visible yet
    n_cmp++; if (f_en !== 8'h00) begin n_fail++; $display("FAIL note_on_latency: got %h want 00", f_en); end
    idle(1);
    n_cmp++; if (lane(0) !== R69) begin n_fail++; $display("FAIL note_on_sp: got %0d want %0d", lane(0), R69); end
    n_cmp++; if (f_en !== 8'h01) begin n_fail++; $display("FAIL note_on_en: got %h want 01", f_en); end
    n_cmp++; if (note_active !== 8'h01) begin n_fail++; $display("FAIL note_on_led: got %h want 01", note_active); end
    n_cmp++; if (err_cnt !== 0) begin n_fail++; $display("FAIL note_on_err: got %0d want 0", err_cnt); end
  endtask

  task automatic test_running_status;
    send(8'h93); send(8'h3C); send(8'h40); idle(1);
    n_cmp++; if (lane(3) !== R60) begin n_fail++; $display("FAIL rs_first_sp: got %0d want %0d", lane(3), R60); end
    n_cmp++; if (f_en !== 8'h09) begin n_fail++; $display("FAIL rs_first_en: got %h want 09", f_en); end
    send(8'h3E); send(8'h40); idle(1);
    n_cmp++; if (lane(3) !== R62) begin n_fail++; $display("FAIL rs_second_sp: got %0d want %0d", lane(3), R62); end
    send(8'h3C); send(8'h00); idle(1);
    n_cmp++; if (f_en !== 8'h09) begin n_fail++; $display("FAIL rs_nomatch_off_en: got %h want 09", f_en); end
    n_cmp++; if (lane(3) !== R62) begin n_fail++; $display("FAIL rs_hold_sp: got %0d want %0d", lane(3), R62); end
  endtask

  task automatic test_realtime;
    err_cnt = 0;
    send(8'h91); send(8'hF8); send(8'h40); send(8'hFE); send(8'h7F); idle(1);
    n_cmp++; if (lane(1) !== R64) begin n_fail++; $display("FAIL rt_sp: got %0d want %0d", lane(1), R64); end
    n_cmp++; if (f_en !== 8'h0B) begin n_fail++; $display("FAIL rt_en: got %h want 0B", f_en); end
    n_cmp++; if (err_cnt !== 0) begin n_fail++; $display("FAIL rt_err: got %0d want 0", err_cnt); end
  endtask

  task automatic test_boundaries;
    err_cnt = 0;
    send(8'h92); send(8'h17); send(8'h40);
    send(8'h92); send(8'h54); send(8'h40);
    send(8'h9A); send(8'h45); send(8'h40);
    send(8'h82); send(8'h45); send(8'h00);
    idle(2);
    n_cmp++; if (f_en !== 8'h0B) begin n_fail++; $display("FAIL bound_reject_en: got %h want 0B", f_en); end
    n_cmp++; if (lane(2) !== 22'd0) begin n_fail++; $display("FAIL bound_reject_sp2: got %0d want 0", lane(2)); end
    n_cmp++; if (lane(0) !== R69) begin n_fail++; $display("FAIL bound_ch10_sp0: got %0d want %0d", lane(0), R69); end
    n_cmp++; if (err_cnt !== 0) begin n_fail++; $display("FAIL bound_err: got %0d want 0", err_cnt); end
    send(8'h92); send(8'h18); send(8'h40); idle(1);
    n_cmp++; if (lane(2) !== R24) begin n_fail++; $display("FAIL bound_min_sp: got %0d want %0d", lane(2), R24); end
    n_cmp++; if (f_en !== 8'h0F) begin n_fail++; $display("FAIL bound_min_en: got %h want 0F", f_en); end
    send(8'h53); send(8'h40); idle(1);
    n_cmp++; if (lane(2) !== R83) begin n_fail++; $display("FAIL bound_max_sp: got %0d want %0d", lane(2), R83); end
  endtask

  task automatic test_back_to_back;
    err_cnt = 0;
    send(8'h94); send(8'h45); send(8'h64); send(8'h45);
    n_cmp++; if (f_en !== 8'h1F) begin n_fail++; $display("FAIL b2b_on_en: got %h want 1F", f_en); end
    send(8'h00); idle(1);
    n_cmp++; if (f_en !== 8'h0F) begin n_fail++; $display("FAIL b2b_off_en: got %h want 0F", f_en); end
    n_cmp++; if (lane(4) !== R69) begin n_fail++; $display("FAIL b2b_hold_sp: got %0d want %0d", lane(4), R69); end
    send(8'hC4); send(8'h05); send(8'h06); send(8'hD4); send(8'h10); send(8'h20); idle(2);
    n_cmp++; if (f_en !== 8'h0F) begin n_fail++; $display("FAIL b2b_onebyte_en: got %h want 0F", f_en); end
    n_cmp++; if (err_cnt !== 0) begin n_fail++; $display("FAIL b2b_onebyte_err: got %0d want 0", err_cnt); end
  endtask

  task automatic test_err_sysex;
    do_reset();
    rx_data = 8'h45; new_rx_data = 1'b1;
    @(negedge clk);
    new_rx_data = 1'b0;
    n_cmp++; if (err_pulse !== 1'b1) begin n_fail++; $display("FAIL err_pulse_high: got %b want 1", err_pulse); end
    @(negedge clk);
    n_cmp++; if (err_pulse !== 1'b0) begin n_fail++; $display("FAIL err_pulse_width: got %b want 0", err_pulse); end
    err_cnt = 0;
    send(8'hF0); send(8'h01); send(8'h02); send(8'hF7); send(8'h03); idle(2);
    n_cmp++; if (err_cnt !== 0) begin n_fail++; $display("FAIL sysex_err: got %0d want 0", err_cnt); end
    n_cmp++; if (f_en !== 8'h00) begin n_fail++; $display("FAIL sysex_en: got %h want 00", f_en); end
    n_cmp++; if (f_sp !== 176'd0) begin n_fail++; $display("FAIL sysex_sp: got %h want 0", f_sp); end
  endtask

  task automatic test_cc_reset;
    do_reset();
    for (int ch = 0; ch < 8; ch++) begin
      send(8'h90 | 8'(ch)); send(8'h3C + 8'(ch)); send(8'h40);
    end
    idle(1);
    n_cmp++; if (f_en !== 8'hFF) begin n_fail++; $display("FAIL cc_all_on: got %h want FF", f_en); end
    send(8'hB5); send(8'h7B); send(8'h00); idle(1);
    n_cmp++; if (f_en !== 8'hDF) begin n_fail++; $display("FAIL cc123_en: got %h want DF", f_en); end
    n_cmp++; if (lane(5) !== R65) begin n_fail++; $display("FAIL cc123_sp_hold: got %0d want %0d", lane(5), R65); end
    send(8'hB6); send(8'h78); send(8'h00); idle(1);
    n_cmp++; if (f_en !== 8'h9F) begin n_fail++; $display("FAIL cc120_en: got %h want 9F", f_en); end
    send(8'hB7); send(8'h07); send(8'h40); idle(1);
    n_cmp++; if (f_en !== 8'h9F) begin n_fail++; $display("FAIL cc_other_en: got %h want 9F", f_en); end
    send(8'h80); send(8'h3C); send(8'h00); idle(1);
    n_cmp++; if (f_en !== 8'h9E) begin n_fail++; $display("FAIL note_off_match_en: got %h want 9E", f_en); end
    // reset in the middle of a message
    send(8'h90); send(8'h45);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    err_cnt = 0;
    send(8'h40);
    n_cmp++; if (err_cnt !== 1) begin n_fail++; $display("FAIL midrst_err: got %0d want 1", err_cnt); end
    idle(2);
    n_cmp++; if (f_en !== 8'h00) begin n_fail++; $display("FAIL midrst_en: got %h want 00", f_en); end
    n_cmp++; if (f_sp !== 176'd0) begin n_fail++; $display("FAIL midrst_sp: got %h want 0", f_sp); end
  endtask

  initial begin
    rst         = 1'b1;
    rx_data     = 8'h00;
    new_rx_data = 1'b0;
    @(negedge clk);
    test_reset();
    test_note_on();
    test_running_status();
    test_realtime();
    test_boundaries();
    test_back_to_back();
    test_err_sysex();
    test_cc_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
